depar_seg_splitter: RTL

Parametrised front-end splitter for the deparser. It replaces the fixed two-segment split with NUM_HDR_SEGS header segments. The block pops beats from the packet FIFO and packs the first NUM_HDR_SEGS beats into one wide header word for the deparsing stage. It extracts the VLAN ID from beat 0 into a separate stream and forwards all remaining beats unchanged as the payload stream.

---
 rtl/depar_pkg.sv | 19 +
 rtl/depar_hdr_packer.sv | 63 ++++++
 rtl/depar_seg_splitter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/depar_pkg.sv
// Shared definitions for the deparser segment splitter.
//   state_t      : splitter FSM encoding (S_HDR=0, S_PUSH=1, S_PAY=2)
//   VLAN_LSB_DEF : default bit offset of the VLAN ID inside beat-0 tdata
//   seg_idx_w()  : header segment index width, never narrower than 1 bit
package depar_pkg;

  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_PUSH = 2'd1,
    S_PAY  = 2'd2
  } state_t;

  localparam int VLAN_LSB_DEF = 116;

  function automatic int seg_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/depar_hdr_packer.sv
// Header segment buffer for the deparser splitter.
// Stores up to NUM_SEGS beats, one per segment slot, with a per-slot valid
// mask. A clear empties every slot so unfilled segments of the next packet
// read back as zero with seg_vld=0 and tlast=0.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   wr_en, wr_idx       : write the wr_* beat into segment wr_idx
//   wr_tdata/tkeep/tuser/tlast : beat being written
//   clr                 : zero the whole buffer and valid mask
//   seg_tdata/tkeep/tuser/tlast/seg_vld : packed buffer contents
module depar_hdr_packer
  import depar_pkg::*;
#(
  parameter int DATA_W   = 256,
  parameter int USER_W   = 128,
  parameter int NUM_SEGS = 2,
  parameter int IDX_W    = seg_idx_w(NUM_SEGS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [IDX_W-1:0]             wr_idx,
  input  logic [DATA_W-1:0]            wr_tdata,
  input  logic [DATA_W/8-1:0]          wr_tkeep,
  input  logic [USER_W-1:0]            wr_tuser,
  input  logic                         wr_tlast,
  input  logic                         clr,
  output logic [NUM_SEGS*DATA_W-1:0]   seg_tdata,
  output logic [NUM_SEGS*DATA_W/8-1:0] seg_tkeep,
  output logic [NUM_SEGS*USER_W-1:0]   seg_tuser,
  output logic [NUM_SEGS-1:0]          seg_tlast,
  output logic [NUM_SEGS-1:0]          seg_vld
);

  localparam int KEEP_W = DATA_W / 8;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_tdata <= '0;
      seg_tkeep <= '0;
      seg_tuser <= '0;
      seg_tlast <= '0;
      seg_vld   <= '0;
    end else if (clr) begin
      seg_tdata <= '0;
      seg_tkeep <= '0;
      seg_tuser <= '0;
      seg_tlast <= '0;
      seg_vld   <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < NUM_SEGS; k++) begin
        if (int'(wr_idx) == k) begin
          seg_tdata[k*DATA_W +: DATA_W] <= wr_tdata;
          seg_tkeep[k*KEEP_W +: KEEP_W] <= wr_tkeep;
          seg_tuser[k*USER_W +: USER_W] <= wr_tuser;
          seg_tlast[k]                  <= wr_tlast;
          seg_vld[k]                    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/depar_seg_splitter.sv
// Deparser front-end splitter.
// Pops beats from a FWFT packet FIFO, packs the first NUM_HDR_SEGS beats of
// each packet into one wide header word, extracts the VLAN ID from beat 0,
// and forwards the remaining beats unchanged as the payload stream.
// Optional feature macro: DEPAR_SEG_STATS_EN enables saturating packet and
// short-packet counters; without it stat_* are tied to zero.
// Ports:
//   axis_clk, areset          : clock, asynchronous active-high reset
//   pkt_fifo_*                : FWFT packet FIFO (data/keep/user/last/empty, rd_en pop)
//   hdr_* / hdr_valid/ready   : packed header word, segment k at [k*W +: W]
//   vlan_id / vlan_valid/ready: VLAN ID stream
//   pay_* / pay_valid/ready   : payload pass-through stream
//   stat_pkts, stat_short_pkts: statistics counters
module depar_seg_splitter
  import depar_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_HDR_SEGS       = 2,
  parameter int C_VLANID_WIDTH     = 12,
  parameter int VLAN_LSB           = VLAN_LSB_DEF,
  parameter int STAT_W             = 32
) (
  input  logic                                          axis_clk,
  input  logic                                          areset,
  input  logic [C_AXIS_DATA_WIDTH-1:0]                  pkt_fifo_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]                pkt_fifo_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]                 pkt_fifo_tuser,
  input  logic                                          pkt_fifo_tlast,
  input  logic                                          pkt_fifo_empty,
  output logic                                          pkt_fifo_rd_en,
  output logic [NUM_HDR_SEGS*C_AXIS_DATA_WIDTH-1:0]     hdr_tdata,
  output logic [NUM_HDR_SEGS*C_AXIS_TUSER_WIDTH-1:0]    hdr_tuser,
  output logic [NUM_HDR_SEGS*C_AXIS_DATA_WIDTH/8-1:0]   hdr_tkeep,
  output logic [NUM_HDR_SEGS-1:0]                       hdr_tlast,
  output logic [NUM_HDR_SEGS-1:0]                       hdr_seg_vld,
  output logic                                          hdr_valid,
  input  logic                                          hdr_ready,
  output logic [C_VLANID_WIDTH-1:0]                     vlan_id,
  output logic                                          vlan_valid,
  input  logic                                          vlan_ready,
  output logic [C_AXIS_DATA_WIDTH-1:0]                  pay_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]                pay_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]                 pay_tuser,
  output logic                                          pay_tlast,
  output logic                                          pay_valid,
  input  logic                                          pay_ready,
  output logic [STAT_W-1:0]                             stat_pkts,
  output logic [STAT_W-1:0]                             stat_short_pkts
);

  localparam int               IDX_W    = seg_idx_w(NUM_HDR_SEGS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_HDR_SEGS - 1);

  state_t           state, state_next;
  logic [IDX_W-1:0] idx;
  logic             pkt_done;
  logic             rd_en_c;
  logic             hdr_pop;
  logic             final_pop;
  logic             push_done;
  logic             clr;
  logic             in_pay;

  always_comb begin
    state_next = state;
    rd_en_c    = 1'b0;
    clr        = 1'b0;
    case (state)
      S_HDR: begin
        rd_en_c = ~pkt_fifo_empty;
        if (rd_en_c && (pkt_fifo_tlast || idx == LAST_IDX))
          state_next = S_PUSH;
      end
      S_PUSH: begin
        if (push_done) begin
          clr        = 1'b1;
          state_next = pkt_done ? S_HDR : S_PAY;
        end
      end
      S_PAY: begin
        rd_en_c = ~pkt_fifo_empty & pay_ready;
        if (rd_en_c && pkt_fifo_tlast)
          state_next = S_HDR;
      end
      default: state_next = S_HDR;
    endcase
  end

  // The pop strobe is combinational from state, so it is masked while reset
  // is held to guarantee no beat is consumed during reset.
  assign pkt_fifo_rd_en = rd_en_c & ~areset;
  assign hdr_pop        = pkt_fifo_rd_en & (state == S_HDR);
  assign final_pop      = hdr_pop & (pkt_fifo_tlast | (idx == LAST_IDX));
  // Each sink retires independently; the push ends once neither is pending.
  assign push_done      = (state == S_PUSH) & (~hdr_valid | hdr_ready) &
                          (~vlan_valid | vlan_ready);

  always_ff @(posedge axis_clk or posedge areset) begin
    if (areset) begin
      state      <= S_HDR;
      idx        <= '0;
      pkt_done   <= 1'b0;
      hdr_valid  <= 1'b0;
      vlan_valid <= 1'b0;
      vlan_id    <= '0;
    end else begin
      state <= state_next;
      if (hdr_pop) begin
        if (idx == '0)
          vlan_id <= pkt_fifo_tdata[VLAN_LSB +: C_VLANID_WIDTH];
        if (final_pop) begin
          pkt_done   <= pkt_fifo_tlast;
          hdr_valid  <= 1'b1;
          vlan_valid <= 1'b1;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end
      if (state == S_PUSH) begin
        if (hdr_valid && hdr_ready)
          hdr_valid <= 1'b0;
        if (vlan_valid && vlan_ready)
          vlan_valid <= 1'b0;
      end
      if (clr)
        idx <= '0;
    end
  end

  depar_hdr_packer #(
    .DATA_W   (C_AXIS_DATA_WIDTH),
    .USER_W   (C_AXIS_TUSER_WIDTH),
    .NUM_SEGS (NUM_HDR_SEGS),
    .IDX_W    (IDX_W)
  ) u_packer (
    .clk       (axis_clk),
    .rst       (areset),
    .wr_en     (hdr_pop),
    .wr_idx    (idx),
    .wr_tdata  (pkt_fifo_tdata),
    .wr_tkeep  (pkt_fifo_tkeep),
    .wr_tuser  (pkt_fifo_tuser),
    .wr_tlast  (pkt_fifo_tlast),
    .clr       (clr),
    .seg_tdata (hdr_tdata),
    .seg_tkeep (hdr_tkeep),
    .seg_tuser (hdr_tuser),
    .seg_tlast (hdr_tlast),
    .seg_vld   (hdr_seg_vld)
  );

  // Payload path is a straight wire from the FIFO head while in S_PAY.
  assign in_pay    = (state == S_PAY);
  assign pay_tdata = in_pay ? pkt_fifo_tdata : '0;
  assign pay_tkeep = in_pay ? pkt_fifo_tkeep : '0;
  assign pay_tuser = in_pay ? pkt_fifo_tuser : '0;
  assign pay_tlast = in_pay & pkt_fifo_tlast;
  assign pay_valid = in_pay & ~pkt_fifo_empty & ~areset;

`ifdef DEPAR_SEG_STATS_EN
  logic [STAT_W-1:0] pkts_cnt;
  logic [STAT_W-1:0] short_cnt;
  logic              hdr_hs;

  assign hdr_hs = hdr_valid & hdr_ready;

  always_ff @(posedge axis_clk or posedge areset) begin
    if (areset) begin
      pkts_cnt  <= '0;
      short_cnt <= '0;
    end else if (hdr_hs) begin
      if (~&pkts_cnt)
        pkts_cnt <= pkts_cnt + STAT_W'(1);
      if (pkt_done && !(&hdr_seg_vld) && ~&short_cnt)
        short_cnt <= short_cnt + STAT_W'(1);
    end
  end

  assign stat_pkts       = pkts_cnt;
  assign stat_short_pkts = short_cnt;
`else
  assign stat_pkts       = '0;
  assign stat_short_pkts = '0;
`endif

endmodule
